// File: rtl/restador_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : restador_multiciclo
// Purpose  : N-bit subtractor Q = A - B processed W bits per clock, LS chunk
//            first, with registered NZCV flags. Define RESTADOR_BORROW_EN to
//            add the bIn port (subtract-with-borrow).
// Revision : 1.0 - initial release
// ============================================================================
module restador_multiciclo #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef RESTADOR_BORROW_EN
    input  logic         bIn,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic         negativo,
    output logic         zero,
    output logic         cOut,
    output logic         overflow
);

    localparam int c_K     = N / W;
    localparam int c_IDX_W = (c_K > 1) ? $clog2(c_K) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(c_K - 1);

    localparam logic c_IDLE = 1'b0;
    localparam logic c_RUN  = 1'b1;

    generate
        if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_param_check
            $error("restador_multiciclo: need N >= 2, 1 <= W <= N, N %% W == 0");
        end
    endgenerate

    logic               r_state;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_borrow;
    logic [c_IDX_W-1:0] r_idx;
    logic [N-1:0]       r_work;

    logic               w_bin;
    logic [W:0]         w_diff;
    logic [N-1:0]       w_next_work;
    logic               w_last;

`ifdef RESTADOR_BORROW_EN
    assign w_bin = bIn;
`else
    assign w_bin = 1'b0;
`endif

    // Operands shift right each cycle, so the active chunk is always the low W bits.
    assign w_diff = {1'b0, r_a[W-1:0]} - {1'b0, r_b[W-1:0]} - {{W{1'b0}}, r_borrow};
    assign w_last = (r_idx == c_LAST);

    // Result chunks enter at the top and move down; after K cycles the word is aligned.
    generate
        if (W == N) begin : g_single_chunk
            assign w_next_work = w_diff[W-1:0];
        end else begin : g_multi_chunk
            assign w_next_work = {w_diff[W-1:0], r_work[N-1:W]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_work   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Q        <= '0;
            negativo <= 1'b0;
            zero     <= 1'b0;
            cOut     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (start) begin
                    r_a      <= A;
                    r_b      <= B;
                    r_a_msb  <= A[N-1];
                    r_b_msb  <= B[N-1];
                    r_borrow <= w_bin;
                    r_idx    <= '0;
                    r_work   <= '0;
                    busy     <= 1'b1;
                    r_state  <= c_RUN;
                end
            end else begin
                r_a      <= r_a >> W;
                r_b      <= r_b >> W;
                r_borrow <= w_diff[W];
                r_work   <= w_next_work;
                r_idx    <= r_idx + 1'b1;
                if (w_last) begin
                    Q        <= w_next_work;
                    negativo <= w_next_work[N-1];
                    zero     <= (w_next_work == '0);
                    cOut     <= ~w_diff[W];
                    overflow <= (r_a_msb != r_b_msb) && (w_next_work[N-1] != r_a_msb);
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= c_IDLE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_restador_multiciclo.sv
`default_nettype none
// ============================================================================
// Module   : tb_restador_multiciclo
// Purpose  : Self-checking bench for restador_multiciclo (N=32, W=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_restador_multiciclo;

    localparam int N = 32;
    localparam int W = 8;
    localparam int K = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         bIn;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic         negativo;
    logic         zero;
    logic         cOut;
    logic         overflow;

    restador_multiciclo #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
`ifdef RESTADOR_BORROW_EN
        .bIn      (bIn),
`endif
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .negativo (negativo),
        .zero     (zero),
        .cOut     (cOut),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic         n, z, c, v;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [N-1:0] a, b, q;
        logic         n, z, c, v;
    } vec_t;

    exp_t sb[$];
    exp_t m_e;
    vec_t tbl[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi);
        exp_t       e;
        logic [N:0] d;
        d   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bi};
        e.q = d[N-1:0];
        e.n = d[N-1];
        e.z = (d[N-1:0] == '0);
        e.c = ~d[N];
        e.v = (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
        e.cyc = 0;
        return e;
    endfunction

    // Scoreboard consumer: every done must match the oldest pending expectation.
    always @(negedge clk) begin
        check("busy_done_exclusive", {31'b0, busy & done}, 32'd0);
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("done_latency", cyc, m_e.cyc);
                check("Q", Q, m_e.q);
                check("negativo", {31'b0, negativo}, {31'b0, m_e.n});
                check("zero", {31'b0, zero}, {31'b0, m_e.z});
                check("cOut", {31'b0, cOut}, {31'b0, m_e.c});
                check("overflow", {31'b0, overflow}, {31'b0, m_e.v});
            end
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi, input exp_t e);
        exp_t x;
        int   t;
        x = e;
        t = 0;
        while (busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
        A = a; B = b; bIn = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x.cyc = cyc + K;
        sb.push_back(x);
        A = $urandom; B = $urandom; bIn = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0 || busy) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_Q"}, Q, '0);
        check({tag, "_flags"}, {27'b0, negativo, zero, cOut, overflow, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        exp_t e;
        tbl[0] = '{a:32'h00000005, b:32'h00000005, q:32'h00000000, n:0, z:1, c:1, v:0};
        tbl[1] = '{a:32'h00000003, b:32'h00000005, q:32'hFFFFFFFE, n:1, z:0, c:0, v:0};
        tbl[2] = '{a:32'h80000000, b:32'h00000001, q:32'h7FFFFFFF, n:0, z:0, c:1, v:1};
        tbl[3] = '{a:32'h00000100, b:32'h00000001, q:32'h000000FF, n:0, z:0, c:1, v:0};
        tbl[4] = '{a:32'h00000000, b:32'h00000001, q:32'hFFFFFFFF, n:1, z:0, c:0, v:0};
        tbl[5] = '{a:32'h7FFFFFFF, b:32'hFFFFFFFF, q:32'h80000000, n:1, z:0, c:0, v:1};
        tbl[6] = '{a:32'h12345678, b:32'h12345679, q:32'hFFFFFFFF, n:1, z:0, c:0, v:0};
        tbl[7] = '{a:32'hFFFFFFFF, b:32'h00000001, q:32'hFFFFFFFE, n:1, z:0, c:1, v:0};

        rst = 1'b1; start = 1'b0; A = '0; B = '0; bIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            e = '{q:tbl[i].q, n:tbl[i].n, z:tbl[i].z, c:tbl[i].c, v:tbl[i].v, cyc:0};
            issue(tbl[i].a, tbl[i].b, 1'b0, e);
            drain();
        end
        repeat (3) @(posedge clk);
        #1;
        check("q_hold", Q, 32'hFFFFFFFE);

        for (int i = 0; i < 4; i++) begin
            logic [N-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            issue(ra, rb, 1'b0, model(ra, rb, 1'b0));
            drain();
        end

        // start pulsed during RUN must be ignored
        issue(32'h00000100, 32'h00000001, 1'b0, model(32'h00000100, 32'h00000001, 1'b0));
        @(posedge clk); #1;
        A = 32'd5; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (8) @(posedge clk);
        #1;
        check("ignored_start_busy", {31'b0, busy}, 32'd0);
        check("ignored_start_Q", Q, 32'h000000FF);

        // start held through the done cycle: back-to-back
        A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        e = model(32'd3, 32'd5, 1'b0);
        e.cyc = cyc + K;
        sb.push_back(e);
        A = 32'h80000000; B = 32'd1;
        repeat (K) @(posedge clk);
        #1;
        check("b2b_done_cycle", {31'b0, done}, 32'd1);
        e = model(32'h80000000, 32'd1, 1'b0);
        e.cyc = cyc + 1 + K;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_busy", {31'b0, busy}, 32'd1);
        drain();

        // asynchronous reset mid-RUN aborts the operation
        A = 32'd9; B = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_Q", Q, '0);
        issue(32'd9, 32'd2, 1'b0, model(32'd9, 32'd2, 1'b0));
        drain();

        // borrow-in feature
`ifdef RESTADOR_BORROW_EN
        e = '{q:32'hFFFFFFFF, n:1, z:0, c:0, v:0, cyc:0};
`else
        e = '{q:32'h00000000, n:0, z:1, c:1, v:0, cyc:0};
`endif
        issue(32'd5, 32'd5, 1'b1, e);
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
